// File: rtl/pipelined_sub16_if.sv
// Operand/result handshake bundle for pipelined_sub16.
// master drives operands, flush and out_ready; slave is the subtractor.
interface pipelined_sub16_if #(
   parameter int unsigned DATA_W = 16
) ();
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] diff;
   logic              borrow;
   logic              ovf;

   modport master (
      output flush, in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow, ovf
   );

   modport slave (
      input  flush, in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow, ovf
   );
endinterface

// File: rtl/pipelined_sub16.sv
// Pipelined a - b, one nibble per stage (LS nibble first), borrow rippled through registers.
// Define SUB_SAT_EN to saturate diff on signed overflow.
module pipelined_sub16 #(
   parameter int unsigned DATA_W = 16
) (
   input logic              clk,
   input logic              rst_n,
   pipelined_sub16_if.slave bus
);
   localparam int unsigned N   = DATA_W / 4;
   localparam int unsigned MSB = DATA_W - 1;

   logic              valid_q [N];
   logic              valid_d [N];
   logic [DATA_W-1:0] a_q     [N];
   logic [DATA_W-1:0] a_d     [N];
   logic [DATA_W-1:0] b_q     [N];
   logic [DATA_W-1:0] b_d     [N];
   logic [DATA_W-1:0] d_q     [N];
   logic [DATA_W-1:0] d_d     [N];
   logic              c_q     [N];
   logic              c_d     [N];
   logic              borrow_q, borrow_d;
   logic              ovf_q, ovf_d;

   logic              stall, accept;
   logic [DATA_W-1:0] src_a   [N];
   logic [DATA_W-1:0] src_b   [N];
   logic [DATA_W-1:0] src_d   [N];
   logic              src_c   [N];
   logic              src_v   [N];
   logic [4:0]        nib     [N];
   logic [DATA_W-1:0] res     [N];
   logic              a_msb, b_msb, ovf_new;
   logic [DATA_W-1:0] last_new;

   assign stall        = valid_q[N-1] && !bus.out_ready;
   assign bus.in_ready = !stall && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.out_valid = valid_q[N-1];
   assign bus.diff      = d_q[N-1];
   assign bus.borrow    = borrow_q;
   assign bus.ovf       = ovf_q;

   always_comb begin
      // Stage inputs: stage 0 from the ports (carry-in 1), stage k from stage k-1.
      src_a[0] = bus.a;
      src_b[0] = bus.b;
      src_d[0] = '0;
      src_c[0] = 1'b1;
      src_v[0] = accept;
      for (int k = 1; k < N; k++) begin
         src_a[k] = a_q[k-1];
         src_b[k] = b_q[k-1];
         src_d[k] = d_q[k-1];
         src_c[k] = c_q[k-1];
         src_v[k] = valid_q[k-1];
      end

      for (int k = 0; k < N; k++) begin
         nib[k] = {1'b0, src_a[k][4*k +: 4]} + {1'b0, ~src_b[k][4*k +: 4]} + {4'b0, src_c[k]};
         res[k] = src_d[k];
         res[k][4*k +: 4] = nib[k][3:0];
      end

      a_msb    = src_a[N-1][MSB];
      b_msb    = src_b[N-1][MSB];
      ovf_new  = (a_msb != b_msb) && (res[N-1][MSB] != a_msb);
      last_new = res[N-1];
`ifdef SUB_SAT_EN
      if (ovf_new) begin
         last_new = a_msb ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
`endif

      for (int k = 0; k < N; k++) begin
         valid_d[k] = valid_q[k];
         a_d[k]     = a_q[k];
         b_d[k]     = b_q[k];
         d_d[k]     = d_q[k];
         c_d[k]     = c_q[k];
      end
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      if (bus.flush) begin
         for (int k = 0; k < N; k++) valid_d[k] = 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < N; k++) begin
            valid_d[k] = src_v[k];
            // Data only moves with a valid op so outputs hold across bubbles.
            if (src_v[k]) begin
               a_d[k] = src_a[k];
               b_d[k] = src_b[k];
               d_d[k] = res[k];
               c_d[k] = nib[k][4];
            end
         end
         if (src_v[N-1]) begin
            d_d[N-1] = last_new;
            borrow_d = ~nib[N-1][4];
            ovf_d    = ovf_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            d_q[k]     <= '0;
            c_q[k]     <= 1'b0;
         end
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            valid_q[k] <= valid_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            d_q[k]     <= d_d[k];
            c_q[k]     <= c_d[k];
         end
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end
endmodule
